// File: rtl/bitserial_add_pkg.sv
// Shared types and width helpers for the bit-serial shared adder.
// Optional subtract support is enabled by defining BITSERIAL_ADD_SUB_EN.
package bitserial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Requester-ID width: at least one bit even for tiny arbiters.
    function automatic int id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bitserial_fa.sv
// Serial full adder: two half adders, an OR for carry, and the carry flop.
// preset wins over clear so a subtract can seed carry=1 on load.
module bitserial_fa (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic preset,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic sum_bit,
    output logic carry
);
    logic w_s0;
    logic w_c0;
    logic w_c1;
    logic r_carry;

    bitserial_ha u_ha0 (.a(a_bit), .b(b_bit),   .sum(w_s0),    .carry(w_c0));
    bitserial_ha u_ha1 (.a(w_s0),  .b(r_carry), .sum(sum_bit), .carry(w_c1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_carry <= 1'b0;
        else if (preset) r_carry <= 1'b1;
        else if (clear)  r_carry <= 1'b0;
        else if (en)     r_carry <= w_c0 | w_c1;
    end

    assign carry = r_carry;
endmodule

// File: rtl/bitserial_ha.sv
// Half adder: the building block of the serial full-adder cell.
module bitserial_ha (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

// File: rtl/bitserial_add_arbiter.sv
// Round-robin arbiter sharing one bit-serial adder cell among NUM_REQ requesters.
// Define BITSERIAL_ADD_SUB_EN to add per-requester subtract (req_sub).
module bitserial_add_arbiter
    import bitserial_add_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef BITSERIAL_ADD_SUB_EN
    input  logic [NUM_REQ-1:0]       req_sub,
`endif
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout,
    output logic [ID_W-1:0]          res_id,
    output state_t                   dbg_state
);
    localparam int CNT_W = cnt_w(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_ready is combinational from state and req_valid; res_valid is high only in DONE.

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_grant_found;
    logic               w_accept;
    logic               w_sub;
    logic               w_sum_bit;
    logic               w_carry;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;

    // First valid index at or above rr_ptr, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_accept = w_grant_found && (r_state == IDLE) && !rst;
    assign w_a_sel  = req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_b_sel  = req_b[int'(w_grant_idx)*WIDTH +: WIDTH];

`ifdef BITSERIAL_ADD_SUB_EN
    assign w_sub = req_sub[w_grant_idx];
`else
    assign w_sub = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    req_ready    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) w_state_next = DONE;
            end
            DONE: begin
                if (res_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    bitserial_fa u_fa (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept & ~w_sub),
        .preset  (w_accept & w_sub),
        .en      (r_state == SHIFT),
        .a_bit   (r_a[0]),
        .b_bit   (r_b[0]),
        .sum_bit (w_sum_bit),
        .carry   (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_a      <= w_a_sel;
            r_b      <= w_sub ? ~w_b_sel : w_b_sel;
            r_cnt    <= '0;
            r_id     <= w_grant_idx;
            r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end else if (r_state == SHIFT) begin
            // LSB-first: each new sum bit enters at the MSB and settles into place after WIDTH shifts.
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sum <= {w_sum_bit, r_sum[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign res_valid = (r_state == DONE);
    assign res_sum   = r_sum;
    assign res_cout  = w_carry;
    assign res_id    = r_id;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_bitserial_add_arbiter.sv
// Directed, table-driven bench for bitserial_add_arbiter (NUM_REQ=4, WIDTH=8).
module tb_bitserial_add_arbiter;
    import bitserial_add_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_sub;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_sum;
    logic                     res_cout;
    logic [ID_W-1:0]          res_id;
    state_t                   dbg_state;

    int checks   = 0;
    int failures = 0;

    bitserial_add_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef BITSERIAL_ADD_SUB_EN
        .req_sub   (req_sub),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

`ifdef BITSERIAL_ADD_SUB_EN
    localparam int NVEC = 8;
`else
    localparam int NVEC = 6;
`endif
    vec_t vecs[NVEC];

    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic sub);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_sub[idx]              = sub;
    endtask

    task automatic run_single(input vec_t v);
        set_req(v.idx, v.a, v.b, v.sub);
        req_valid = 4'b0001 << v.idx;
        #1;
        check("single_ready", 32'(req_ready), 32'(4'b0001 << v.idx));
        tick();
        req_valid = '0;
        check("single_state_shift", 32'(dbg_state), 32'(SHIFT));
        repeat (WIDTH - 1) tick();
        check("single_valid_early", 32'(res_valid), 32'd0);
        tick();
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_sum", 32'(res_sum), 32'(v.exp_sum));
        check("single_cout", 32'(res_cout), 32'(v.exp_cout));
        check("single_id", 32'(res_id), 32'(v.idx));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("single_valid_drop", 32'(res_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  rr_a[4];
        logic [7:0]  rr_b[4];
        logic [8:0]  full;
        logic [10:0] exp;
        int          got;
        int          rr_ids[5];

        vecs[0] = '{idx: 2, a: 8'h3C, b: 8'h05, sub: 1'b0, exp_sum: 8'h41, exp_cout: 1'b0};
        vecs[1] = '{idx: 0, a: 8'hFF, b: 8'h01, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[2] = '{idx: 1, a: 8'h80, b: 8'h80, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[3] = '{idx: 3, a: 8'h12, b: 8'h34, sub: 1'b0, exp_sum: 8'h46, exp_cout: 1'b0};
        vecs[4] = '{idx: 0, a: 8'hAA, b: 8'h55, sub: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b0};
        vecs[5] = '{idx: 3, a: 8'hFF, b: 8'hFF, sub: 1'b0, exp_sum: 8'hFE, exp_cout: 1'b1};
`ifdef BITSERIAL_ADD_SUB_EN
        vecs[6] = '{idx: 1, a: 8'h10, b: 8'h01, sub: 1'b1, exp_sum: 8'h0F, exp_cout: 1'b1};
        vecs[7] = '{idx: 2, a: 8'h01, b: 8'h02, sub: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b0};
`endif

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        res_ready = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_cout", 32'(res_cout), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) run_single(vecs[i]);

        // Round robin with all four requesting continuously from reset
        do_reset();
        rr_a = '{8'h01, 8'h7F, 8'hF0, 8'h99};
        rr_b = '{8'h02, 8'h81, 8'h20, 8'h66};
        rr_ids = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            full = {1'b0, rr_a[rr_ids[i]]} + {1'b0, rr_b[rr_ids[i]]};
            exp_q.push_back({2'(rr_ids[i]), full});
        end
        req_valid = 4'hF;
        res_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 300 && got < 5; cyc++) begin
            @(posedge clk);
            #1;
            check("rr_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (res_valid) begin
                exp = exp_q.pop_front();
                check("rr_result_id_cout_sum", 32'({res_id, res_cout, res_sum}), 32'(exp));
                got++;
            end
        end
        check("rr_result_count", 32'(got), 32'd5);
        req_valid = '0;
        tick();
        res_ready = 1'b0;

        // Backpressure: hold DONE for 20 cycles
        set_req(1, 8'h7F, 8'h01, 1'b0);
        set_req(2, 8'h05, 8'h06, 1'b0);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        wait_valid(40, "bp");
        for (int i = 0; i < 20; i++) begin
            check("bp_hold_outputs", 32'({res_valid, res_id, res_cout, res_sum}), 32'({1'b1, 2'd1, 1'b0, 8'h80}));
            check("bp_req_ready_zero", 32'(req_ready), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_valid_drop", 32'(res_valid), 32'd0);
        check("bp_state_idle", 32'(dbg_state), 32'(IDLE));
        check("bp_next_grant", 32'(req_ready), 32'(4'b0100));
        tick();
        req_valid = '0;
        wait_valid(40, "bp2");
        check("bp2_result", 32'({res_id, res_cout, res_sum}), 32'({2'd2, 1'b0, 8'h0B}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset in SHIFT cycle 4 aborts and clears rr_ptr
        set_req(1, 8'hFF, 8'h03, 1'b0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("abort_in_shift", 32'(dbg_state), 32'(SHIFT));
        set_req(1, 8'h20, 8'h22, 1'b0);
        set_req(3, 8'h11, 8'h22, 1'b0);
        req_valid = 4'b1010;
        rst = 1'b1;
        #1;
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_sum", 32'(res_sum), 32'd0);
        check("abort_res_cout", 32'(res_cout), 32'd0);
        check("abort_res_id", 32'(res_id), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_rr_ptr_zero_grant", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        wait_valid(40, "abort_new");
        check("abort_new_result", 32'({res_id, res_cout, res_sum}), 32'({2'd1, 1'b0, 8'h42}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("abort_new_drop", 32'(res_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
